// File: rtl/instr_register_exec.sv
// Instruction register: captures opcode/operand writes, computes each result, commits it
// to a 2**ADDR_W-entry array and returns entries on a registered read port.
// Optional macro IR_FAST_DIV_EN: single-cycle DIV/MOD in EXEC instead of the serial divider.
package instr_register_pkg;
    localparam int unsigned IR_OP_W  = 32;
    localparam int unsigned IR_RES_W = 64;

    typedef enum logic [2:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef struct packed {
        opcode_t               opc;
        logic [IR_OP_W-1:0]    op_a;
        logic [IR_OP_W-1:0]    op_b;
        logic [IR_RES_W-1:0]   result;
    } instruction_t;
endpackage

module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = IR_OP_W,
    parameter int unsigned RES_W  = IR_RES_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    output logic              load_ready,
    input  opcode_t           opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [ADDR_W-1:0] read_pointer,
    output instruction_t      instruction_word,
    output logic              busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE, EXEC, COMMIT
`ifndef IR_FAST_DIV_EN
        , DIVIDE
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    opcode_t             opc_q, opc_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [RES_W-1:0]    a_ext, b_ext;
    instruction_t        mem_q [DEPTH];
    instruction_t        rd_q;

    function automatic logic [RES_W-1:0] sext(input logic [OP_W-1:0] v);
        return {{(RES_W - OP_W){v[OP_W-1]}}, v};
    endfunction

    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? ('0 - v) : v;
    endfunction

    // Quotient truncates toward zero, remainder takes the dividend's sign; magnitudes are
    // unsigned so -2**(OP_W-1) / -1 wraps back to -2**(OP_W-1).
    function automatic logic [RES_W-1:0] div_fix(input logic [OP_W-1:0] q_mag,
                                                 input logic [OP_W-1:0] r_mag,
                                                 input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b,
                                                 input logic            is_mod);
        logic [OP_W-1:0] q, r;
        q = (a[OP_W-1] ^ b[OP_W-1]) ? ('0 - q_mag) : q_mag;
        r = a[OP_W-1] ? ('0 - r_mag) : r_mag;
        return sext(is_mod ? r : q);
    endfunction

`ifndef IR_FAST_DIV_EN
    localparam int unsigned CNT_W = $clog2(OP_W + 1);

    logic [OP_W:0]      rem_q, rem_d, rem_sh, rem_diff;
    logic [OP_W-1:0]    quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    assign a_ext = sext(a_q);
    assign b_ext = sext(b_q);

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        opc_d      = opc_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        load_ready = 1'b0;
`ifndef IR_FAST_DIV_EN
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        rem_sh     = {rem_q[OP_W-1:0], quo_q[OP_W-1]};
        rem_diff   = rem_sh - {1'b0, dvs_q};
`endif

        case (state_q)
            IDLE: begin
                load_ready = ~reset;
                if (load_en) begin
                    wp_d    = write_pointer;
                    opc_d   = opcode;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = COMMIT;
                case (opc_q)
                    ZERO:  res_d = '0;
                    PASSA: res_d = a_ext;
                    PASSB: res_d = b_ext;
                    ADD:   res_d = a_ext + b_ext;
                    SUB:   res_d = a_ext - b_ext;
                    MULT:  res_d = a_ext * b_ext;
                    default: begin
                        if (b_q == '0) begin
                            res_d = '0;
                        end else begin
`ifdef IR_FAST_DIV_EN
                            res_d = div_fix(mag(a_q) / mag(b_q), mag(a_q) % mag(b_q),
                                            a_q, b_q, opc_q == MOD);
`else
                            rem_d   = '0;
                            quo_d   = mag(a_q);
                            dvs_d   = mag(b_q);
                            cnt_d   = CNT_W'(OP_W);
                            state_d = DIVIDE;
`endif
                        end
                    end
                endcase
            end
`ifndef IR_FAST_DIV_EN
            DIVIDE: begin
                // Restoring step: quotient bits shift in at the bottom as dividend bits leave the top.
                if (!rem_diff[OP_W]) begin
                    rem_d = rem_diff;
                    quo_d = {quo_q[OP_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[OP_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = div_fix(quo_d, rem_d[OP_W-1:0], a_q, b_q, opc_q == MOD);
                    state_d = COMMIT;
                end
            end
`endif
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            opc_q   <= ZERO;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rd_q    <= mem_q[read_pointer];
            if (state_q == COMMIT) begin
                mem_q[wp_q] <= '{opc: opc_q, op_a: a_q, op_b: b_q, result: res_q};
            end
        end
    end

`ifndef IR_FAST_DIV_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign instruction_word = rd_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_instr_register_exec.sv
// Directed bench for instr_register_exec with hand-computed expected entries and latencies.
// Honours IR_FAST_DIV_EN for the expected DIV/MOD latency.
module tb_instr_register_exec;
    import instr_register_pkg::*;

`ifdef IR_FAST_DIV_EN
    localparam int unsigned DIV_LAT = 2;
`else
    localparam int unsigned DIV_LAT = 34;
`endif
    localparam int unsigned STD_LAT = 2;

    logic         clk;
    logic         reset;
    logic         load_en;
    logic         load_ready;
    opcode_t      opcode;
    logic [31:0]  operand_a;
    logic [31:0]  operand_b;
    logic [4:0]   write_pointer;
    logic [4:0]   read_pointer;
    instruction_t instruction_word;
    logic         busy;

    int unsigned n_tests;
    int unsigned n_fail;

    instr_register_exec #(.ADDR_W(5), .OP_W(32), .RES_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .load_ready       (load_ready),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] r);
        instruction_t t;
        t.opc    = o;
        t.op_a   = a;
        t.op_b   = b;
        t.result = r;
        return t;
    endfunction

    // Called just after a negedge; returns the number of cycles load_ready stayed low.
    task automatic do_write(input logic [4:0] wp, input opcode_t o, input logic [31:0] a,
                            input logic [31:0] b, output int unsigned lat);
        write_pointer = wp;
        opcode        = o;
        operand_a     = a;
        operand_b     = b;
        load_en       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        check("busy_after_accept", 192'(busy), 192'(1'b1));
        lat = 0;
        while (!load_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic write_check(input string tag, input logic [4:0] wp, input opcode_t o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] r, input int unsigned exp_lat);
        int unsigned lat;
        do_write(wp, o, a, b, lat);
        check({tag, "_lat"}, 192'(lat), 192'(exp_lat));
        read_pointer = wp;
        @(negedge clk);
        check(tag, 192'(instruction_word), 192'(mk(o, a, b, r)));
    endtask

    initial begin
        int unsigned lat;
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        load_en       = 1'b0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        write_pointer = '0;
        read_pointer  = 5'd5;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 192'(load_ready), 192'(1'b0));
        check("rst_busy", 192'(busy), 192'(1'b0));
        check("rst_word", 192'(instruction_word), 192'(0));
        reset = 1'b0;
        #1;
        check("ready_after_rst", 192'(load_ready), 192'(1'b1));
        @(negedge clk);
        check("read5_after_rst", 192'(instruction_word), 192'(0));

        // Arithmetic opcodes
        write_check("add", 5'd3, ADD, 32'(-7), 32'd12, 64'd5, STD_LAT);
        write_check("sub", 5'd4, SUB, 32'd3, 32'd9, 64'hFFFF_FFFF_FFFF_FFFA, STD_LAT);
        write_check("mult", 5'd6, MULT, 32'(-15), 32'd15, 64'(-225), STD_LAT);
        write_check("mult_big", 5'd12, MULT, 32'h8000_0000, 32'h8000_0000,
                    64'h4000_0000_0000_0000, STD_LAT);
        write_check("zero", 5'd13, ZERO, 32'd44, 32'd55, 64'd0, STD_LAT);
        write_check("passa", 5'd14, PASSA, 32'(-2), 32'd55, 64'(-2), STD_LAT);
        write_check("passb", 5'd15, PASSB, 32'd1, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, STD_LAT);

        // Division, remainder and boundaries
        write_check("div", 5'd7, DIV, 32'(-15), 32'd4, 64'(-3), DIV_LAT);
        write_check("mod", 5'd8, MOD, 32'(-15), 32'd4, 64'(-3), DIV_LAT);
        write_check("div_negb", 5'd16, DIV, 32'd100, 32'(-7), 64'(-14), DIV_LAT);
        write_check("mod_negb", 5'd17, MOD, 32'd100, 32'(-7), 64'd2, DIV_LAT);
        write_check("div_by0", 5'd18, DIV, 32'd9, 32'd0, 64'd0, STD_LAT);
        write_check("mod_by0", 5'd19, MOD, 32'(-9), 32'd0, 64'd0, STD_LAT);
        write_check("div_ovf", 5'd20, DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, DIV_LAT);
        write_check("mod_ovf", 5'd21, MOD, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, DIV_LAT);
        read_pointer = 5'd3;
        @(negedge clk);
        check("add_kept", 192'(instruction_word), 192'(mk(ADD, 32'(-7), 32'd12, 64'd5)));

        // Reset while a write is in flight aborts it
        write_pointer = 5'd9;
        opcode        = DIV;
        operand_a     = 32'd100;
        operand_b     = 32'd3;
        load_en       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
`ifndef IR_FAST_DIV_EN
        repeat (10) @(negedge clk);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 192'(busy), 192'(1'b0));
        #1;
        check("abort_ready", 192'(load_ready), 192'(1'b1));
        repeat (40) @(negedge clk);
        read_pointer = 5'd9;
        @(negedge clk);
        check("abort_entry9", 192'(instruction_word), 192'(0));

        // load_en held during busy: only first write lands; read-before-write on commit
        write_check("pre10", 5'd10, PASSA, 32'd5, 32'd0, 64'd5, STD_LAT);
        write_pointer = 5'd10;
        opcode        = ADD;
        operand_a     = 32'd1;
        operand_b     = 32'd2;
        load_en       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write_pointer = 5'd11;
        opcode        = PASSB;
        operand_a     = 32'd0;
        operand_b     = 32'd77;
        lat = 0;
        while (!load_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        load_en = 1'b0;
        check("held_lat", 192'(lat), 192'(STD_LAT));
        check("rbw_old", 192'(instruction_word), 192'(mk(PASSA, 32'd5, 32'd0, 64'd5)));
        @(negedge clk);
        check("rbw_new", 192'(instruction_word), 192'(mk(ADD, 32'd1, 32'd2, 64'd3)));
        read_pointer = 5'd11;
        @(negedge clk);
        check("ignored_wp11", 192'(instruction_word), 192'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
